cheshire_idma_chan_sched: RTL and testbench



---
 rtl/cheshire_idma_pkg.sv | 28 ++
 rtl/cheshire_idma_tag_fifo.sv | 63 ++++++
 rtl/cheshire_idma_chan_sched.sv | 164 ++++++++++++++++
 tb/tb_cheshire_idma_chan_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_idma_pkg.sv
// Shared types and helpers for the Cheshire iDMA multi-channel job scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cheshire_idma_pkg;

    // Static configuration bundle used when wiring the scheduler into the SoC top.
    typedef struct packed {
        int unsigned num_chan;
        int unsigned id_width;
        int unsigned inflight_depth;
    } idma_chan_sched_cfg_t;

    localparam idma_chan_sched_cfg_t DefaultSchedCfg = '{
        num_chan:       4,
        id_width:       32,
        inflight_depth: 8
    };

    // A single channel still needs a 1-bit index so the tag FIFO has a width.
    function automatic int unsigned chan_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ChanIdxW = chan_idx_width(DefaultSchedCfg.num_chan);

    typedef logic [ChanIdxW-1:0] chan_idx_t;

endpackage

// File: rtl/cheshire_idma_tag_fifo.sv
// Tag FIFO recording the issuing channel of every job outstanding at the backend.
// Latency: 1 cycle push-to-head; no fall-through, head is read straight from storage.
// Backpressure: full_o/empty_o flags; push when full or pop when empty is ignored.
//
// Ports: clk_i/rst_i (sync active-high), push_i/data_i write side,
//        pop_i/data_o read side (data_o = current head), full_o, empty_o.
module cheshire_idma_tag_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cheshire_idma_chan_sched.sv
// Round-robin job scheduler from NumChan iDMA frontends onto one backend, with per-channel IDs.
// Latency: 0 cycles job path (combinational grant); ID/busy/err updates visible next cycle.
// Backpressure: job_ready_i forwarded to the granted channel only; grant locked until handshake;
//               no grant while InflightDepth jobs are outstanding. Completions always accepted.
//
// Ports: clk_i/rst_i; chan_en_i, job_i, job_valid_i, job_ready_o (frontend side);
//        job_o, job_chan_o, job_valid_o, job_ready_i (backend job side);
//        rsp_valid_i, rsp_ready_o (in-order completions); next_id_o, done_id_o, busy_o, err_o.
module cheshire_idma_chan_sched
    import cheshire_idma_pkg::*;
#(
    parameter int unsigned NumChan       = DefaultSchedCfg.num_chan,
    parameter int unsigned IdWidth       = DefaultSchedCfg.id_width,
    parameter int unsigned InflightDepth = DefaultSchedCfg.inflight_depth,
    parameter type         job_t         = logic
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumChan-1:0]                     chan_en_i,
    input  job_t                                   job_i [NumChan],
    input  logic [NumChan-1:0]                     job_valid_i,
    output logic [NumChan-1:0]                     job_ready_o,
    output job_t                                   job_o,
    output logic [chan_idx_width(NumChan)-1:0]     job_chan_o,
    output logic                                   job_valid_o,
    input  logic                                   job_ready_i,
    input  logic                                   rsp_valid_i,
    output logic                                   rsp_ready_o,
    output logic [NumChan-1:0][IdWidth-1:0]        next_id_o,
    output logic [NumChan-1:0][IdWidth-1:0]        done_id_o,
    output logic [NumChan-1:0]                     busy_o,
    output logic                                   err_o
);

    localparam int unsigned ChanSelW = chan_idx_width(NumChan);
    localparam int unsigned OutW     = $clog2(InflightDepth + 1);

    logic [ChanSelW-1:0] rr_q;
    logic                lock_q;
    logic [ChanSelW-1:0] lock_idx_q;
    logic                err_q;

    logic                tag_full;
    logic                tag_empty;
    logic [ChanSelW-1:0] tag_head;

    logic [NumChan-1:0]  eligible;
    logic                arb_vld;
    logic [ChanSelW-1:0] arb_idx;
    logic [ChanSelW-1:0] grant_idx;
    logic                grant_vld;
    logic                hs;
    logic                pop;
    int unsigned         arb_k;

    // Full is taken before any same-cycle pop, so a retiring job never frees a slot early.
    assign eligible = job_valid_i & chan_en_i & {NumChan{~tag_full}};

    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        arb_k   = 0;
        for (int unsigned i = 0; i < NumChan; i++) begin
            arb_k = (int'(rr_q) + i) % NumChan;
            if (!arb_vld && eligible[ChanSelW'(arb_k)]) begin
                arb_vld = 1'b1;
                arb_idx = ChanSelW'(arb_k);
            end
        end
    end

    // A stalled offer stays pinned to its channel regardless of chan_en_i so valid/payload
    // remain stable until the backend takes it. Reset masks the offer so nothing is pushed.
    assign grant_idx = lock_q ? lock_idx_q : arb_idx;
    assign grant_vld = ~rst_i & (lock_q | arb_vld);

    assign job_valid_o = grant_vld;
    assign job_chan_o  = grant_idx;
    assign job_o       = job_i[grant_idx];
    assign hs          = grant_vld & job_ready_i;
    assign pop         = rsp_valid_i & ~tag_empty;
    assign rsp_ready_o = 1'b1;
    assign err_o       = err_q;

    always_comb begin
        job_ready_o = '0;
        if (grant_vld) begin
            job_ready_o[grant_idx] = job_ready_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant_vld && !job_ready_i) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant_idx;
            end else if (hs) begin
                lock_q     <= 1'b0;
            end
            if (hs) begin
                rr_q <= (grant_idx == ChanSelW'(NumChan - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (rsp_valid_i && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    cheshire_idma_tag_fifo #(
        .Depth (InflightDepth),
        .Width (ChanSelW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (grant_idx),
        .pop_i   (pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        logic               issue;
        logic               retire;
        logic [IdWidth-1:0] next_id_q;
        logic [IdWidth-1:0] done_id_q;
        logic [OutW-1:0]    outstanding_q;

        assign issue  = hs & (grant_idx == ChanSelW'(c));
        assign retire = pop & (tag_head == ChanSelW'(c));

        // IDs wrap naturally at 2^IdWidth; 0 is a legal ID after wrap.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                next_id_q     <= IdWidth'(1);
                done_id_q     <= '0;
                outstanding_q <= '0;
            end else begin
                if (issue) begin
                    next_id_q <= next_id_q + 1'b1;
                end
                if (retire) begin
                    done_id_q <= done_id_q + 1'b1;
                end
                case ({issue, retire})
                    2'b10:   outstanding_q <= outstanding_q + 1'b1;
                    2'b01:   outstanding_q <= outstanding_q - 1'b1;
                    default: outstanding_q <= outstanding_q;
                endcase
            end
        end

        assign next_id_o[c] = next_id_q;
        assign done_id_o[c] = done_id_q;
        assign busy_o[c]    = (outstanding_q != '0);
    end

endmodule

// File: tb/tb_cheshire_idma_chan_sched.sv
// Directed self-checking bench for the multi-channel iDMA job scheduler (4 channels, 4-bit IDs).
// Latency: n/a.
// Backpressure: n/a.
module tb_cheshire_idma_chan_sched;

    logic             clk;
    logic             rst;
    logic [3:0]       chan_en;
    logic [15:0]      job_in [4];
    logic [3:0]       job_valid_in;
    logic [3:0]       job_ready_out;
    logic [15:0]      job_out;
    logic [1:0]       job_chan;
    logic             job_valid_out;
    logic             job_ready_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0][3:0]  next_id;
    logic [3:0][3:0]  done_id;
    logic [3:0]       busy;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    cheshire_idma_chan_sched #(
        .NumChan       (4),
        .IdWidth       (4),
        .InflightDepth (8),
        .job_t         (logic [15:0])
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .chan_en_i   (chan_en),
        .job_i       (job_in),
        .job_valid_i (job_valid_in),
        .job_ready_o (job_ready_out),
        .job_o       (job_out),
        .job_chan_o  (job_chan),
        .job_valid_o (job_valid_out),
        .job_ready_i (job_ready_in),
        .rsp_valid_i (rsp_valid),
        .rsp_ready_o (rsp_ready),
        .next_id_o   (next_id),
        .done_id_o   (done_id),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        chan_en      = 4'hF;
        job_valid_in = '0;
        job_ready_in = 1'b0;
        rsp_valid    = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) job_in[c] = 16'hA0 + 16'(c);
        reset_dut();

        // Reset state
        check_eq("rst_next_id", 32'(next_id), 32'h1111);
        check_eq("rst_done_id", 32'(done_id), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_job_valid", 32'(job_valid_out), 32'h0);
        check_eq("rst_job_ready", 32'(job_ready_out), 32'h0);
        check_eq("rsp_ready", 32'(rsp_ready), 32'h1);

        // 1: single job on ch2, zero-latency grant, then one completion
        job_valid_in = 4'b0100;
        job_ready_in = 1'b1;
        #1;
        check_eq("t1_valid", 32'(job_valid_out), 32'h1);
        check_eq("t1_chan", 32'(job_chan), 32'h2);
        check_eq("t1_job", 32'(job_out), 32'hA2);
        check_eq("t1_ready_o", 32'(job_ready_out), 32'b0100);
        tick();
        job_valid_in = '0;
        #1;
        check_eq("t1_next_id2", 32'(next_id[2]), 32'h2);
        check_eq("t1_busy_set", 32'(busy), 32'b0100);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        #1;
        check_eq("t1_done_id2", 32'(done_id[2]), 32'h1);
        check_eq("t1_busy_clr", 32'(busy), 32'h0);

        // 2: all channels valid -> round robin until the tag FIFO fills
        reset_dut();
        job_valid_in = 4'hF;
        job_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq($sformatf("t2_order%0d", i), 32'(job_chan), 32'(i % 4));
            tick();
        end
        #1;
        check_eq("t2_full_valid", 32'(job_valid_out), 32'h0);
        check_eq("t2_full_ready", 32'(job_ready_out), 32'h0);
        check_eq("t2_cnt", 32'(dut.u_tag_fifo.cnt_q), 32'h8);
        check_eq("t2_next_id", 32'(next_id), 32'h3333);
        check_eq("t2_busy", 32'(busy), 32'hF);

        // 4: FIFO full with same-cycle completion -> no grant until next cycle
        job_valid_in = 4'b0001;
        rsp_valid    = 1'b1;
        #1;
        check_eq("t4_no_grant", 32'(job_valid_out), 32'h0);
        tick();
        rsp_valid = 1'b0;
        #1;
        check_eq("t4_cnt7", 32'(dut.u_tag_fifo.cnt_q), 32'h7);
        check_eq("t4_grant", 32'(job_valid_out), 32'h1);
        check_eq("t4_chan", 32'(job_chan), 32'h0);
        tick();
        job_valid_in = '0;
        #1;
        check_eq("t4_cnt8", 32'(dut.u_tag_fifo.cnt_q), 32'h8);
        check_eq("t4_done_id", 32'(done_id), 32'h0001);
        check_eq("t4_next_id", 32'(next_id), 32'h3334);
        rsp_valid = 1'b1;
        repeat (8) tick();
        rsp_valid = 1'b0;
        #1;
        check_eq("t4_drain_done", 32'(done_id), 32'h2223);
        check_eq("t4_drain_busy", 32'(busy), 32'h0);

        // 5: completion with nothing outstanding -> sticky error, counters untouched
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        #1;
        check_eq("t5_err", 32'(err), 32'h1);
        check_eq("t5_done_id", 32'(done_id), 32'h2223);
        check_eq("t5_next_id", 32'(next_id), 32'h3334);
        repeat (3) tick();
        check_eq("t5_err_sticky", 32'(err), 32'h1);

        // 3: stalled offer on ch1 stays put when its enable drops
        reset_dut();
        check_eq("t3_err_cleared", 32'(err), 32'h0);
        job_valid_in = 4'b0010;
        job_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) chan_en = 4'b1101;
            #1;
            check_eq($sformatf("t3_valid%0d", i), 32'(job_valid_out), 32'h1);
            check_eq($sformatf("t3_chan%0d", i), 32'(job_chan), 32'h1);
            check_eq($sformatf("t3_rdy%0d", i), 32'(job_ready_out), 32'h0);
            tick();
        end
        job_ready_in = 1'b1;
        #1;
        check_eq("t3_hs_ready", 32'(job_ready_out), 32'b0010);
        tick();
        check_eq("t3_unlock", 32'(job_valid_out), 32'h0);
        check_eq("t3_next_id", 32'(next_id), 32'h1121);
        job_valid_in = '0;
        chan_en      = 4'hF;

        // 6: ID wrap on ch0 over 16 issue/retire pairs
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            job_valid_in = 4'b0001;
            job_ready_in = 1'b1;
            #1;
            check_eq($sformatf("t6_next%0d", k), 32'(next_id[0]), 32'((k + 1) % 16));
            tick();
            job_valid_in = '0;
            rsp_valid    = 1'b1;
            tick();
            rsp_valid = 1'b0;
        end
        #1;
        check_eq("t6_wrap_next", 32'(next_id), 32'h1111);
        check_eq("t6_wrap_done", 32'(done_id), 32'h0000);

        // Same channel issues and retires in one cycle
        job_valid_in = 4'b0001;
        tick();
        rsp_valid = 1'b1;
        tick();
        job_valid_in = '0;
        rsp_valid    = 1'b0;
        #1;
        check_eq("t6_same_next", 32'(next_id[0]), 32'h3);
        check_eq("t6_same_done", 32'(done_id[0]), 32'h1);
        check_eq("t6_same_busy", 32'(busy), 32'b0001);
        check_eq("t6_same_cnt", 32'(dut.u_tag_fifo.cnt_q), 32'h1);

        // Reset with three jobs in flight
        job_valid_in = 4'b0110;
        repeat (2) tick();
        check_eq("t6_busy3", 32'(busy), 32'b0111);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_next", 32'(next_id), 32'h1111);
        check_eq("t6_rst_done", 32'(done_id), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        check_eq("t6_rst_valid", 32'(job_valid_out), 32'h0);
        check_eq("t6_rst_cnt", 32'(dut.u_tag_fifo.cnt_q), 32'h0);
        rst          = 1'b0;
        job_valid_in = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
